user_str_fetch: RTL and testbench
=================================

# user_str_fetch

OBI manager in the user domain that reads a run of 32-bit words from an OBI subordinate (typically the user ROM holding the ASCII ID string) and serialises them into a byte stream with a valid/ready handshake. Software or a top-level controller pulses a start with a base address and word count. The block issues one read at a time, tolerates grant stalls and bus errors, and reports busy, done and error status.

## Interface
- ObiCfg, obi_pkg::ObiDefaultConfig: OBI configuration (AddrWidth, DataWidth=32, IdWidth).
- obi_req_t, logic: OBI request struct type.
- obi_rsp_t, logic: OBI response struct type.
- MaxWords, 8: maximum words per transfer. Count width is CntW = $clog2(MaxWords+1).
- clk_i  in  1  clock, single domain.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  start pulse. Ignored while busy_o=1.
- base_addr_i  in  AddrWidth  byte address of first word. Bits [1:0] are forced to 0.
- num_words_i  in  CntW  words to fetch. Values above MaxWords are clamped to MaxWords.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle pulse at end of transfer, normal or aborted.
- err_o  out  1  sticky; set on any rsp.r.err; cleared on accepted start.
- obi_req_o  out  obi_req_t  OBI A channel to subordinate.
- obi_rsp_i  in  obi_rsp_t  OBI gnt and R channel from subordinate.
- char_valid_o  out  1  byte valid.
- char_ready_i  in  1  byte consumed when char_valid_o & char_ready_i.
- char_o  out  8  byte data.

## Operation
- FSM states: IDLE, REQ, WAIT_R, DRAIN, DONE. Word index idx is CntW bits; byte index bidx is 2 bits.
- IDLE: on start_i, latch base and clamped count, clear err_o and idx. Go to DONE if count==0, else go to REQ.
- REQ: drive req=1, we=0, be='1, wdata=0, aid=0, addr = base + (idx<<2), wrapping modulo 2^AddrWidth. Hold all A fields stable until gnt. On gnt go to WAIT_R.
- WAIT_R: req=0. rready=1 if the config has it. On rvalid, capture rdata.
  - If r.err: set err_o and go to DONE. No bytes are emitted from the errored word.
  - Otherwise set bidx=0 and go to DRAIN.
- DRAIN: char_o = word[8*bidx +: 8], so bytes go out LSB first. Advance on handshake. After byte 3: idx++. If idx==count go to DONE, else go to REQ.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
- At most one outstanding transaction. rvalid outside WAIT_R is ignored.
- Reset (any state, mid-transfer included): IDLE. All outputs are 0, with obi_req_o all-zero and err_o=0. In-flight response data is discarded.

## Timing
- Start accepted in cycle 0: req=1 in cycle 1.
- With a combinational gnt and 1-cycle rvalid: gnt in cycle 1, rvalid in cycle 2, char_valid_o in cycle 3.
- With char_ready_i held high: bytes in cycles 3 to 6, next req in cycle 7, so 6 cycles per word.
- char_valid_o is only ever high in DRAIN. char_o is stable while valid and not ready.
- start_i and rvalid in the same cycle are independent: start is ignored because the block is busy.
- done_o coincides with busy_o falling. A start in the DONE cycle is ignored. A start in the following IDLE cycle is accepted.

## Configuration
- USER_STR_FETCH_NUL_STOP_EN defined: a 0x00 byte is emitted normally. After its handshake the block goes straight to DONE, drops the remaining bytes and issues no further requests.
- Not defined: all 4*count bytes are emitted regardless of value.

## Structure
- Package user_str_fetch_pkg holds:
  - the state enum fetch_state_e (IDLE, REQ, WAIT_R, DRAIN, DONE);
  - localparam BytesPerWord = 4;
  - localparam NulChar = 8'h00.
- Natural sub-module user_str_fetch_unpack: a word register plus bidx counter with valid/ready output, loaded on rvalid, and a "last byte" flag back to the FSM.

## Test plan
- Basic fetch: ROM words 0x01,0x02 at 0x0, start with base=0x0, num=2, ready high. Required: bytes 01,00,00,00,02,00,00,00; done_o pulse in cycle 13; err_o=0.
- Gnt stall: gnt held low 3 cycles with req high. Required: addr and req stable throughout; the single request is issued at 0x4 when base=0x4.
- Back-pressure: char_ready_i toggling 1/0 on word 0x64636261. Required: 'a','b','c','d' in order, each held stable until its handshake, no duplicates.
- Error abort: subordinate returns err=1 on word 1 of 3. Required: 4 bytes from word 0 only; err_o=1 until next start; done_o pulses once.
- Edge counts: num=0 gives a done_o pulse in cycle 1 with no req. num=MaxWords+3 fetches exactly MaxWords words. base=0xFFFF_FFFC with num=2 wraps the second address to 0x0.
- NUL stop and reset: with USER_STR_FETCH_NUL_STOP_EN, string "AB\0x" gives 41,42,00 then done. Asserting rst_i during WAIT_R gives req=0, busy_o=0, char_valid_o=0 immediately.

Source files
------------

// File: rtl/user_str_fetch_pkg.sv
// rtl/user_str_fetch_pkg.sv - shared types and constants for the user string fetcher
package user_str_fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_R,
      DRAIN,
      DONE
   } fetch_state_e;

   localparam int BytesPerWord = 4;
   localparam logic [7:0] NulChar = 8'h00;

   localparam int AddrWidth = 32;
   localparam int DataWidth = 32;
   localparam int IdWidth   = 1;

   typedef struct packed {
      int unsigned AddrWidth;
      int unsigned DataWidth;
      int unsigned IdWidth;
      logic        UseRReady;
   } obi_cfg_t;

   localparam obi_cfg_t ObiDefaultConfig = '{
      AddrWidth: 32,
      DataWidth: 32,
      IdWidth:   1,
      UseRReady: 1'b1
   };

   typedef struct packed {
      logic [AddrWidth-1:0] addr;
      logic                 we;
      logic [DataWidth/8-1:0] be;
      logic [DataWidth-1:0] wdata;
      logic [IdWidth-1:0]   aid;
   } fetch_obi_a_chan_t;

   typedef struct packed {
      fetch_obi_a_chan_t a;
      logic              req;
      logic              rready;
   } fetch_obi_req_t;

   typedef struct packed {
      logic [DataWidth-1:0] rdata;
      logic [IdWidth-1:0]   rid;
      logic                 err;
   } fetch_obi_r_chan_t;

   typedef struct packed {
      logic              gnt;
      logic              rvalid;
      fetch_obi_r_chan_t r;
   } fetch_obi_rsp_t;

   // Byte i of a little-endian word; byte 0 is the first character of the string
   function automatic logic [7:0] byte_sel(input logic [DataWidth-1:0] w, input logic [1:0] i);
      return w[8*i +: 8];
   endfunction

endpackage

// File: rtl/user_str_fetch_unpack.sv
// rtl/user_str_fetch_unpack.sv - word buffer that hands out one byte at a time, LSB first
module user_str_fetch_unpack
   import user_str_fetch_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load_i,
   input  logic [DataWidth-1:0] word_i,
   input  logic                 drain_i,
   input  logic                 char_ready_i,
   output logic                 char_valid_o,
   output logic [7:0]           char_o,
   output logic                 char_hs_o,
   output logic                 last_o
);

   logic [DataWidth-1:0] word_q;
   logic [1:0]           bidx_q;

   // Reload the word on a clean response, then step the byte index on every consumed byte
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         word_q <= '0;
         bidx_q <= '0;
      end else if (load_i) begin
         word_q <= word_i;
         bidx_q <= '0;
      end else if (char_hs_o) begin
         bidx_q <= bidx_q + 2'd1;
      end
   end

   // Byte data is forced to zero outside the drain phase so idle outputs stay quiet
   assign char_valid_o = drain_i;
   assign char_o       = drain_i ? byte_sel(word_q, bidx_q) : 8'h00;
   assign char_hs_o    = drain_i & char_ready_i;
   assign last_o       = (bidx_q == 2'(BytesPerWord - 1));

endmodule

// File: rtl/user_str_fetch.sv
// rtl/user_str_fetch.sv - OBI manager streaming a run of ROM words out as bytes (option: USER_STR_FETCH_NUL_STOP_EN)
module user_str_fetch
   import user_str_fetch_pkg::*;
#(
   parameter obi_cfg_t    ObiCfg    = ObiDefaultConfig,
   parameter type         obi_req_t = fetch_obi_req_t,
   parameter type         obi_rsp_t = fetch_obi_rsp_t,
   parameter int unsigned MaxWords  = 8,
   localparam int unsigned CntW     = $clog2(MaxWords + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [AddrWidth-1:0] base_addr_i,
   input  logic [CntW-1:0]      num_words_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output obi_req_t             obi_req_o,
   input  obi_rsp_t             obi_rsp_i,
   output logic                 char_valid_o,
   input  logic                 char_ready_i,
   output logic [7:0]           char_o
);

   fetch_state_e         state_q, state_d;
   logic [AddrWidth-1:0] base_q;
   logic [CntW-1:0]      count_q, idx_q;
   logic [CntW-1:0]      num_clamped;
   logic [AddrWidth-1:0] req_addr;
   logic                 err_q;
   logic                 drain, load, char_hs, last_byte, word_done, nul_stop;
   logic                 unused_bits;

   assign num_clamped = (num_words_i > CntW'(MaxWords)) ? CntW'(MaxWords) : num_words_i;
   assign req_addr    = base_q + AddrWidth'({idx_q, 2'b00});
   assign word_done   = ((idx_q + CntW'(1)) == count_q);
   assign load        = (state_q == WAIT_R) & obi_rsp_i.rvalid & ~obi_rsp_i.r.err;
   assign err_o       = err_q;
   assign unused_bits = ^{base_addr_i[1:0], obi_rsp_i.r.rid};

`ifdef USER_STR_FETCH_NUL_STOP_EN
   assign nul_stop = (char_o == NulChar);
`else
   assign nul_stop = 1'b0;
`endif

   user_str_fetch_unpack u_unpack (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .load_i       (load),
      .word_i       (obi_rsp_i.r.rdata),
      .drain_i      (drain),
      .char_ready_i (char_ready_i),
      .char_valid_o (char_valid_o),
      .char_o       (char_o),
      .char_hs_o    (char_hs),
      .last_o       (last_byte)
   );

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Transfer context: latched on an accepted start, word index steps after the fourth byte
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         base_q  <= '0;
         count_q <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (state_q == IDLE && start_i) begin
            base_q  <= {base_addr_i[AddrWidth-1:2], 2'b00};
            count_q <= num_clamped;
            idx_q   <= '0;
            err_q   <= 1'b0;
         end
         if (state_q == WAIT_R && obi_rsp_i.rvalid && obi_rsp_i.r.err) begin
            err_q <= 1'b1;
         end
         if (char_hs && last_byte) begin
            idx_q <= idx_q + CntW'(1);
         end
      end
   end

   // Next-state logic; one outstanding read, responses outside WAIT_R are ignored
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = (num_clamped == '0) ? DONE : REQ;
            end
         end
         REQ: begin
            if (obi_rsp_i.gnt) begin
               state_d = WAIT_R;
            end
         end
         WAIT_R: begin
            if (obi_rsp_i.rvalid) begin
               state_d = obi_rsp_i.r.err ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            if (char_hs) begin
               if (nul_stop) begin
                  state_d = DONE;
               end else if (last_byte) begin
                  state_d = word_done ? DONE : REQ;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decoded from state; A channel fields held constant for the whole REQ phase
   always_comb begin
      obi_req_o = '0;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      drain     = 1'b0;
      unique case (state_q)
         REQ: begin
            busy_o           = 1'b1;
            obi_req_o.req    = 1'b1;
            obi_req_o.a.addr = req_addr;
            obi_req_o.a.be   = '1;
         end
         WAIT_R: begin
            busy_o           = 1'b1;
            obi_req_o.rready = ObiCfg.UseRReady;
         end
         DRAIN: begin
            busy_o = 1'b1;
            drain  = 1'b1;
         end
         DONE: begin
            done_o = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_user_str_fetch.sv
// tb/tb_user_str_fetch.sv - randomized self-checking bench for user_str_fetch
module tb_user_str_fetch;
   import user_str_fetch_pkg::*;

   localparam int MaxW = 8;

   logic           clk   = 1'b0;
   logic           rst   = 1'b1;
   logic           start = 1'b0;
   logic [31:0]    base  = '0;
   logic [3:0]     num   = '0;
   logic           busy, done, err, cv;
   logic           cr    = 1'b0;
   logic [7:0]     ch;
   fetch_obi_req_t oreq;
   fetch_obi_rsp_t orsp  = '0;

   user_str_fetch #(.MaxWords(MaxW)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .base_addr_i  (base),
      .num_words_i  (num),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err),
      .obi_req_o    (oreq),
      .obi_rsp_i    (orsp),
      .char_valid_o (cv),
      .char_ready_i (cr),
      .char_o       (ch)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0, cyc = 0;

   // environment knobs
   int   gnt_pct = 100, min_lat = 0, max_lat = 0, rdy_pct = 100, stall_left = 0;
   bit   rdy_toggle = 0, spur_en = 0, err_en = 0;
   logic [31:0] err_addr = '0;
   logic [31:0] rom [logic [31:0]];

   // subordinate state
   bit          outst = 0, granted = 0;
   int          lat = 0;
   logic [31:0] o_addr = '0;

   // reference model
   bit          m_busy = 0, exp_err = 0;
   logic [7:0]  exp_b [$];
   logic [31:0] exp_a [$];
   logic [7:0]  rx [$];
   logic [31:0] gaddr [$];
   int          ngrant = 0, done_cnt = 0, c0 = 0;
   int          first_req_cyc = -1, first_val_cyc = -1, done_cyc = -1;
   bit          pv_stall = 0, pr_stall = 0;
   logic [7:0]  pv_ch = '0;
   logic [31:0] pr_addr = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (rom.exists(a)) return rom[a];
      return {a[31:24] + 8'h77, a[23:16] ^ 8'h3c, a[15:8] + 8'h11, a[7:0] ^ 8'h5a};
   endfunction

   // What a transfer must produce, straight from the rules: clamp, wrap, LSB first, stop on error/NUL
   task automatic model_start(input logic [31:0] b, input logic [3:0] nw);
      int n;
      bit stop;
      logic [31:0] a, w;
      n = (int'(nw) > MaxW) ? MaxW : int'(nw);
      exp_err = 0;
      stop = 0;
      exp_a.delete();
      exp_b.delete();
      for (int i = 0; i < n && !stop; i++) begin
         a = {b[31:2], 2'b00} + 32'(4 * i);
         exp_a.push_back(a);
         if (err_en && a == err_addr) begin
            exp_err = 1;
            stop = 1;
         end else begin
            w = word_at(a);
            for (int k = 0; k < 4 && !stop; k++) begin
               exp_b.push_back(w[8*k +: 8]);
`ifdef USER_STR_FETCH_NUL_STOP_EN
               if (w[8*k +: 8] == 8'h00) stop = 1;
`endif
            end
         end
      end
   endtask

   // Per-cycle monitor, subordinate and byte sink, all evaluated mid-cycle
   always @(negedge clk) begin
      bit accept, g;
      cyc++;
      if (rst) begin
         exp_a.delete();
         exp_b.delete();
         m_busy = 0; exp_err = 0; outst = 0; pv_stall = 0; pr_stall = 0;
         orsp = '0; cr = 0;
      end else begin
         accept = start && !m_busy;
         if (pv_stall) begin
            chk("char_hold_valid", cv, 1);
            chk("char_hold_data", ch, pv_ch);
         end
         if (pr_stall) begin
            chk("req_hold", oreq.req, 1);
            chk("addr_hold", oreq.a.addr, pr_addr);
         end
         if (outst) begin
            chk("wait_r_req", oreq.req, 0);
            chk("wait_r_rready", oreq.rready, 1);
         end
         chk("busy_o", busy, m_busy && !done);
         if (m_busy) chk("err_early", err && !exp_err, 0);
         else chk("err_sticky", err, exp_err);
         if (m_busy && cv && first_val_cyc < 0) first_val_cyc = cyc - c0;
         if (m_busy && oreq.req && first_req_cyc < 0) first_req_cyc = cyc - c0;
         if (done) begin
            done_cnt++;
            done_cyc = cyc - c0;
            chk("done_in_transfer", m_busy, 1);
            chk("done_bytes_left", exp_b.size(), 0);
            chk("done_reqs_left", exp_a.size(), 0);
            chk("done_err", err, exp_err);
            m_busy = 0;
         end
         if (accept) begin
            model_start(base, num);
            c0 = cyc;
            first_req_cyc = -1;
            first_val_cyc = -1;
            m_busy = 1;
         end

         orsp = '0;
         if (outst) begin
            if (lat == 0) begin
               orsp.rvalid  = 1;
               orsp.r.rdata = word_at(o_addr);
               orsp.r.err   = err_en && (o_addr == err_addr);
               outst = 0;
            end else begin
               lat--;
            end
         end else if (spur_en && $urandom_range(0, 3) == 0) begin
            orsp.rvalid  = 1;
            orsp.r.err   = 1;
            orsp.r.rdata = $urandom;
         end
         pr_stall = 0;
         if (oreq.req) begin
            if (stall_left > 0) begin
               g = 0;
               stall_left--;
            end else begin
               g = ($urandom_range(1, 100) <= gnt_pct);
            end
            if (g) begin
               orsp.gnt = 1;
               ngrant++;
               granted = 1;
               gaddr.push_back(oreq.a.addr);
               chk("req_we", oreq.a.we, 0);
               chk("req_be", oreq.a.be, 4'hf);
               chk("req_wdata", oreq.a.wdata, 0);
               if (exp_a.size() == 0) chk("unexpected_req", 1, 0);
               else chk("req_addr", oreq.a.addr, exp_a.pop_front());
               outst  = 1;
               lat    = $urandom_range(min_lat, max_lat);
               o_addr = oreq.a.addr;
            end else begin
               pr_stall = 1;
               pr_addr  = oreq.a.addr;
            end
         end

         cr = rdy_toggle ? !cr : ($urandom_range(1, 100) <= rdy_pct);
         pv_stall = cv && !cr;
         pv_ch    = ch;
         if (cv && cr) begin
            rx.push_back(ch);
            if (exp_b.size() == 0) chk("unexpected_byte", 1, 0);
            else chk("byte", ch, exp_b.pop_front());
         end
      end
   end

   task automatic reset_dut();
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
   endtask

   task automatic pulse_start(input logic [31:0] b, input int n);
      @(posedge clk); #1;
      start = 1; base = b; num = 4'(n);
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic wait_idle(input int budget, input bit spam);
      int k = 0;
      while (m_busy && k < budget) begin
         @(posedge clk); #1;
         start = spam && m_busy && ($urandom_range(0, 5) == 0);
         if (start) begin
            base = $urandom;
            num  = 4'($urandom_range(0, 15));
         end
         k++;
      end
      start = 0;
      if (m_busy) begin
         chk("transfer_timeout", 1, 0);
         reset_dut();
      end
   endtask

   task automatic fresh();
      rx.delete(); gaddr.delete();
      ngrant = 0; done_cnt = 0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      reset_dut();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_valid", cv, 0);
      chk("rst_req_zero", oreq == '0, 1);

      // basic fetch
      rom[32'h0] = 32'h1; rom[32'h4] = 32'h2;
      fresh();
      pulse_start(32'h0, 2);
      wait_idle(500, 0);
      chk("basic_first_req_cycle", first_req_cyc, 1);
      chk("basic_first_valid_cycle", first_val_cyc, 3);
`ifdef USER_STR_FETCH_NUL_STOP_EN
      chk("basic_nul_bytes", rx.size(), 2);
      chk("basic_nul_done_cycle", done_cyc, 5);
`else
      chk("basic_bytes", rx.size(), 8);
      if (rx.size() == 8) chk("basic_stream", {rx[0], rx[1], rx[2], rx[3], rx[4], rx[5], rx[6], rx[7]},
                              64'h01000000_02000000);
      chk("basic_done_cycle", done_cyc, 13);
`endif
      chk("basic_done_pulses", done_cnt, 1);
      chk("basic_err", err, 0);

      // grant stall on a single request
      rom.delete();
      fresh();
      stall_left = 3;
      pulse_start(32'h4, 1);
      wait_idle(500, 0);
      chk("stall_grants", ngrant, 1);
      if (gaddr.size() > 0) chk("stall_addr", gaddr[0], 32'h4);
      chk("stall_done_cycle", done_cyc, 10);

      // back-pressure with alternating ready
      rom[32'h0] = 32'h64636261;
      fresh();
      rdy_toggle = 1;
      pulse_start(32'h0, 1);
      wait_idle(500, 0);
      rdy_toggle = 0;
      chk("bp_bytes", rx.size(), 4);
      if (rx.size() == 4) chk("bp_stream", {rx[0], rx[1], rx[2], rx[3]}, 32'h61626364);

      // error on the second of three words
      rom.delete();
      fresh();
      err_en = 1; err_addr = 32'h4; rdy_pct = 60;
      pulse_start(32'h0, 3);
      wait_idle(500, 0);
      chk("err_bytes", rx.size(), 4);
      chk("err_grants", ngrant, 2);
      chk("err_done_pulses", done_cnt, 1);
      repeat (3) @(posedge clk);
      #1 chk("err_sticky_idle", err, 1);
      err_en = 0; rdy_pct = 100;

      // zero count: immediate done, no request, clears err
      fresh();
      pulse_start(32'h0, 0);
      wait_idle(100, 0);
      chk("zero_done_cycle", done_cyc, 1);
      chk("zero_no_req", first_req_cyc, -1);
      chk("zero_err_cleared", err, 0);

      // count above the maximum is clamped
      fresh();
      pulse_start(32'h200, MaxW + 3);
      wait_idle(1000, 0);
      chk("clamp_grants", ngrant, 8);
      chk("clamp_bytes", rx.size(), 32);

      // address wrap at the top of the space
      fresh();
      pulse_start(32'hFFFF_FFFC, 2);
      wait_idle(500, 0);
      chk("wrap_grants", ngrant, 2);
      if (gaddr.size() == 2) chk("wrap_second_addr", gaddr[1], 32'h0);

      // start in DONE is dropped, start in the following IDLE cycle is taken
      fresh();
      pulse_start(32'h0, 0);
      start = 1; base = 32'h40; num = 4'd1;
      @(posedge clk); #1;
      @(posedge clk); #1 start = 0;
      wait_idle(500, 0);
      chk("done_start_pulses", done_cnt, 2);
      chk("done_start_grants", ngrant, 1);

      // NUL handling on "AB\0x"
      rom[32'h100] = 32'h78004241;
      fresh();
      pulse_start(32'h100, 2);
      wait_idle(500, 0);
`ifdef USER_STR_FETCH_NUL_STOP_EN
      chk("nul_bytes", rx.size(), 3);
      if (rx.size() == 3) chk("nul_stream", {rx[0], rx[1], rx[2]}, 24'h414200);
      chk("nul_grants", ngrant, 1);
`else
      chk("nul_bytes", rx.size(), 8);
      if (rx.size() == 8) chk("nul_stream", {rx[0], rx[1], rx[2], rx[3]}, 32'h41420078);
      chk("nul_grants", ngrant, 2);
`endif

      // reset while waiting for read data
      fresh();
      min_lat = 3; max_lat = 3; granted = 0;
      pulse_start(32'h0, 2);
      for (int k = 0; k < 50 && !granted; k++) @(negedge clk);
      chk("rst_wait_granted", granted, 1);
      @(posedge clk); #1 rst = 1;
      #1;
      chk("rst_mid_req", oreq.req, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_valid", cv, 0);
      chk("rst_mid_done", done, 0);
      chk("rst_mid_req_zero", oreq == '0, 1);
      @(posedge clk); #1 rst = 0;
      min_lat = 0; max_lat = 0;
      fresh();
      pulse_start(32'h8, 1);
      wait_idle(500, 0);
      chk("rst_recover_bytes", rx.size(), 4);

      // randomized transfers with stalls, latency, back-pressure, stray responses and errors
      for (int t = 0; t < 40; t++) begin
         logic [31:0] b;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         gnt_pct = $urandom_range(30, 100);
         max_lat = $urandom_range(0, 3);
         rdy_pct = $urandom_range(30, 100);
         spur_en = $urandom_range(0, 1);
         err_en  = ($urandom_range(0, 3) == 0);
         err_addr = {b[31:2], 2'b00} + 32'(4 * $urandom_range(0, 7));
         fresh();
         pulse_start(b, $urandom_range(0, 15));
         wait_idle(3000, 1);
         chk("rand_done_once", done_cnt, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
